// File: rtl/user_obi_sbr_demux_pkg.sv
`default_nettype none
// =============================================================================
// Package  : user_obi_sbr_demux_pkg
// Brief    : User-domain address map, subordinate indices and error response.
// Revision : 1.0
// =============================================================================
package user_obi_sbr_demux_pkg;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_map_rule_t;

    localparam int unsigned NumUserDomainSubordinates = 4;

    localparam logic [31:0] UserSbr1AddrOffset = 32'h2000_0000;
    localparam logic [31:0] UserSbr1AddrRange  = 32'h0000_1000;
    localparam logic [31:0] UserSbr2AddrOffset = 32'h2000_1000;
    localparam logic [31:0] UserSbr2AddrRange  = 32'h0000_1000;
    localparam logic [31:0] UserSbr3AddrOffset = 32'h2000_2000;
    localparam logic [31:0] UserSbr3AddrRange  = 32'h0000_1000;
    localparam logic [31:0] UserSbr4AddrOffset = 32'h2000_3000;
    localparam logic [31:0] UserSbr4AddrRange  = 32'h0000_1000;

    // Index 0 is always the internal error subordinate.
    typedef enum logic [2:0] {
        UserError = 3'd0,
        UserSbr1  = 3'd1,
        UserSbr2  = 3'd2,
        UserSbr3  = 3'd3,
        UserSbr4  = 3'd4
    } user_demux_outputs_e;

    typedef logic [$clog2(NumUserDomainSubordinates+1)-1:0] user_sbr_idx_t;

    localparam logic [31:0] UserErrRdata = 32'hBADCAB1E;

    localparam addr_map_rule_t [NumUserDomainSubordinates-1:0] user_addr_map = '{
        0: '{idx: 32'(UserSbr1), start_addr: UserSbr1AddrOffset,
             end_addr: UserSbr1AddrOffset + UserSbr1AddrRange},
        1: '{idx: 32'(UserSbr2), start_addr: UserSbr2AddrOffset,
             end_addr: UserSbr2AddrOffset + UserSbr2AddrRange},
        2: '{idx: 32'(UserSbr3), start_addr: UserSbr3AddrOffset,
             end_addr: UserSbr3AddrOffset + UserSbr3AddrRange},
        3: '{idx: 32'(UserSbr4), start_addr: UserSbr4AddrOffset,
             end_addr: UserSbr4AddrOffset + UserSbr4AddrRange}
    };

endpackage
`default_nettype wire

// File: rtl/user_demux_idx_fifo.sv
`default_nettype none
// =============================================================================
// Module   : user_demux_idx_fifo
// Brief    : Order-tracking FIFO of subordinate indices with occupancy count.
// Revision : 1.0
// =============================================================================
module user_demux_idx_fifo
    import user_obi_sbr_demux_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = $bits(user_sbr_idx_t)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_cnt_w = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_ptr_w'(DEPTH-1)) ? '0 : ptr + c_ptr_w'(1);
    endfunction

    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= next_ptr(r_wptr);
            if (w_pop)  r_rptr <= next_ptr(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/user_obi_sbr_demux.sv
`default_nettype none
// =============================================================================
// Module   : user_obi_sbr_demux
// Brief    : OBI demux from one manager to NumSbr user subordinates + error sbr.
// Revision : 1.0
// =============================================================================
module user_obi_sbr_demux
    import user_obi_sbr_demux_pkg::*;
#(
    parameter int unsigned                 NumSbr    = NumUserDomainSubordinates,
    parameter int unsigned                 MaxTrans  = 4,
    parameter int unsigned                 AddrWidth = 32,
    parameter int unsigned                 DataWidth = 32,
    parameter int unsigned                 IdWidth   = 1,
    parameter addr_map_rule_t [NumSbr-1:0] AddrMap   = user_addr_map
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumSbr-1:0]             sbr_en_i,
    input  logic                          mgr_req_i,
    output logic                          mgr_gnt_o,
    input  logic [AddrWidth-1:0]          mgr_addr_i,
    input  logic                          mgr_we_i,
    input  logic [DataWidth/8-1:0]        mgr_be_i,
    input  logic [DataWidth-1:0]          mgr_wdata_i,
    input  logic [IdWidth-1:0]            mgr_aid_i,
    output logic                          mgr_rvalid_o,
    output logic [DataWidth-1:0]          mgr_rdata_o,
    output logic                          mgr_err_o,
    output logic [IdWidth-1:0]            mgr_rid_o,
    output logic [NumSbr-1:0]             sbr_req_o,
    input  logic [NumSbr-1:0]             sbr_gnt_i,
    output logic [AddrWidth-1:0]          sbr_addr_o,
    output logic                          sbr_we_o,
    output logic [DataWidth/8-1:0]        sbr_be_o,
    output logic [DataWidth-1:0]          sbr_wdata_o,
    output logic [IdWidth-1:0]            sbr_aid_o,
    input  logic [NumSbr-1:0]             sbr_rvalid_i,
    input  logic [NumSbr*DataWidth-1:0]   sbr_rdata_i,
    input  logic [NumSbr-1:0]             sbr_err_i,
    input  logic [NumSbr*IdWidth-1:0]     sbr_rid_i,
    output logic                          spurious_o
);

    localparam int unsigned          c_idx_w     = $clog2(NumSbr+1);
    localparam int unsigned          c_cnt_w     = $clog2(MaxTrans+1);
    localparam logic [DataWidth-1:0] c_err_rdata = DataWidth'(UserErrRdata);

    typedef logic [c_idx_w-1:0] idx_t;

    logic [NumSbr-1:0]    w_rule_en;
    logic [NumSbr-1:0]    w_rule_hit;
    logic [NumSbr-1:0]    w_head_sel;
    idx_t                 w_idx;
    idx_t                 w_head;
    logic [c_cnt_w-1:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_stall;
    logic                 w_push;
    logic                 w_rsp_valid;
    logic [DataWidth-1:0] w_rsp_data;
    logic                 w_rsp_err;
    logic [IdWidth-1:0]   w_rsp_rid;

    idx_t                 r_last_idx;
    logic                 r_err_rvalid;
    logic [IdWidth-1:0]   r_err_rid;
    logic                 r_spurious;

    // A rule is only live when its target index exists and that window is enabled.
    for (genvar k = 0; k < NumSbr; k++) begin : g_rule
        localparam logic [AddrWidth-1:0] c_start = AddrWidth'(AddrMap[k].start_addr);
        localparam logic [AddrWidth-1:0] c_end   = AddrWidth'(AddrMap[k].end_addr);
        localparam int unsigned          c_sel   = AddrMap[k].idx;

        if (c_sel >= 1 && c_sel <= NumSbr) begin : g_en
            assign w_rule_en[k] = sbr_en_i[c_sel-1];
        end else begin : g_dis
            assign w_rule_en[k] = 1'b0;
        end

        if (c_end == '0) begin : g_top
            assign w_rule_hit[k] = w_rule_en[k] && (mgr_addr_i >= c_start);
        end else begin : g_bounded
            assign w_rule_hit[k] = w_rule_en[k] && (mgr_addr_i >= c_start)
                                   && (mgr_addr_i < c_end);
        end
    end

    // Walking from the top down lets the lowest-numbered matching rule win.
    always_comb begin
        w_idx = '0;
        for (int k = NumSbr-1; k >= 0; k--) begin
            if (w_rule_hit[k]) w_idx = idx_t'(AddrMap[k].idx);
        end
    end

    assign w_stall = w_full || ((w_count != '0) && (w_idx != r_last_idx));

    always_comb begin
        sbr_req_o = '0;
        mgr_gnt_o = 1'b0;
        if (!w_stall) begin
            if (w_idx == '0) mgr_gnt_o = mgr_req_i;
            for (int k = 0; k < NumSbr; k++) begin
                if (w_idx == idx_t'(k+1)) begin
                    sbr_req_o[k] = mgr_req_i;
                    mgr_gnt_o    = sbr_gnt_i[k];
                end
            end
        end
    end

    assign w_push      = mgr_req_i && mgr_gnt_o;
    assign sbr_addr_o  = mgr_addr_i;
    assign sbr_we_o    = mgr_we_i;
    assign sbr_be_o    = mgr_be_i;
    assign sbr_wdata_o = mgr_wdata_i;
    assign sbr_aid_o   = mgr_aid_i;

    user_demux_idx_fifo #(
        .DEPTH (MaxTrans),
        .WIDTH (c_idx_w)
    ) u_idx_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_push),
        .i_data  (w_idx),
        .i_pop   (w_rsp_valid),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_last_idx   <= '0;
            r_err_rvalid <= 1'b0;
            r_err_rid    <= '0;
        end else begin
            r_err_rvalid <= w_push && (w_idx == '0);
            if (w_push) r_last_idx <= w_idx;
            if (w_push && (w_idx == '0)) r_err_rid <= mgr_aid_i;
        end
    end

    // Only the subordinate at the FIFO head may complete a response.
    always_comb begin
        w_head_sel  = '0;
        w_rsp_valid = 1'b0;
        w_rsp_data  = '0;
        w_rsp_err   = 1'b0;
        w_rsp_rid   = '0;
        if (!w_empty) begin
            if (w_head == '0) begin
                w_rsp_valid = r_err_rvalid;
                w_rsp_data  = c_err_rdata;
                w_rsp_err   = 1'b1;
                w_rsp_rid   = r_err_rid;
            end
            for (int k = 0; k < NumSbr; k++) begin
                if (w_head == idx_t'(k+1)) begin
                    w_head_sel[k] = 1'b1;
                    w_rsp_valid   = sbr_rvalid_i[k];
                    w_rsp_data    = sbr_rdata_i[k*DataWidth +: DataWidth];
                    w_rsp_err     = sbr_err_i[k];
                    w_rsp_rid     = sbr_rid_i[k*IdWidth +: IdWidth];
                end
            end
        end
    end

    assign mgr_rvalid_o = w_rsp_valid;
    assign mgr_rdata_o  = w_rsp_valid ? w_rsp_data : '0;
    assign mgr_err_o    = w_rsp_valid & w_rsp_err;
    assign mgr_rid_o    = w_rsp_valid ? w_rsp_rid : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_spurious <= 1'b0;
        end else if (|(sbr_rvalid_i & ~w_head_sel)) begin
            r_spurious <= 1'b1;
        end
    end

    assign spurious_o = r_spurious;

endmodule
`default_nettype wire

// File: tb/tb_user_obi_sbr_demux.sv
`default_nettype none
// =============================================================================
// Module   : tb_user_obi_sbr_demux
// Brief    : Directed + randomized bench with an in-order transaction model.
// Revision : 1.0
// =============================================================================
module tb_user_obi_sbr_demux;

    localparam int NSBR = 4;
    localparam int MAXT = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int IW   = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NSBR-1:0]   sbr_en_i;
    logic              mgr_req_i;
    logic              mgr_gnt_o;
    logic [AW-1:0]     mgr_addr_i;
    logic              mgr_we_i;
    logic [DW/8-1:0]   mgr_be_i;
    logic [DW-1:0]     mgr_wdata_i;
    logic [IW-1:0]     mgr_aid_i;
    logic              mgr_rvalid_o;
    logic [DW-1:0]     mgr_rdata_o;
    logic              mgr_err_o;
    logic [IW-1:0]     mgr_rid_o;
    logic [NSBR-1:0]   sbr_req_o;
    logic [NSBR-1:0]   sbr_gnt_i;
    logic [AW-1:0]     sbr_addr_o;
    logic              sbr_we_o;
    logic [DW/8-1:0]   sbr_be_o;
    logic [DW-1:0]     sbr_wdata_o;
    logic [IW-1:0]     sbr_aid_o;
    logic [NSBR-1:0]   sbr_rvalid_i;
    logic [NSBR*DW-1:0] sbr_rdata_i;
    logic [NSBR-1:0]   sbr_err_i;
    logic [NSBR*IW-1:0] sbr_rid_i;
    logic              spurious_o;

    user_obi_sbr_demux dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sbr_en_i     (sbr_en_i),
        .mgr_req_i    (mgr_req_i),
        .mgr_gnt_o    (mgr_gnt_o),
        .mgr_addr_i   (mgr_addr_i),
        .mgr_we_i     (mgr_we_i),
        .mgr_be_i     (mgr_be_i),
        .mgr_wdata_i  (mgr_wdata_i),
        .mgr_aid_i    (mgr_aid_i),
        .mgr_rvalid_o (mgr_rvalid_o),
        .mgr_rdata_o  (mgr_rdata_o),
        .mgr_err_o    (mgr_err_o),
        .mgr_rid_o    (mgr_rid_o),
        .sbr_req_o    (sbr_req_o),
        .sbr_gnt_i    (sbr_gnt_i),
        .sbr_addr_o   (sbr_addr_o),
        .sbr_we_o     (sbr_we_o),
        .sbr_be_o     (sbr_be_o),
        .sbr_wdata_o  (sbr_wdata_o),
        .sbr_aid_o    (sbr_aid_o),
        .sbr_rvalid_i (sbr_rvalid_i),
        .sbr_rdata_i  (sbr_rdata_i),
        .sbr_err_i    (sbr_err_i),
        .sbr_rid_i    (sbr_rid_i),
        .spurious_o   (spurious_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            idx;
        logic [IW-1:0] rid;
        logic [DW-1:0] rdata;
        logic          err;
        int            ready;
    } txn_t;

    txn_t            q[$];
    int              last_idx;
    int              cyc;
    int              checks;
    int              errors;
    int              lat;
    int              gnt_cnt, gnt_cyc, rv_cnt, rv_first;
    bit              spur_model;
    logic [DW-1:0]   rsp_data;
    logic [NSBR-1:0] force_rv;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Address map: four 4 KiB windows starting at 0x2000_0000, first enabled hit wins.
    function automatic int ref_decode(input logic [31:0] a, input logic [NSBR-1:0] en);
        logic [31:0] lo;
        for (int k = 0; k < NSBR; k++) begin
            lo = 32'h2000_0000 + 32'(k) * 32'h1000;
            if (en[k] && a >= lo && a < lo + 32'h1000) return k + 1;
        end
        return 0;
    endfunction

    task automatic cycle();
        txn_t            t;
        int              eidx;
        bit              stall, egnt, erv, drv, spur_hit;
        logic [NSBR-1:0] ereq;
        sbr_rvalid_i = '0;
        sbr_rdata_i  = '0;
        sbr_err_i    = '0;
        sbr_rid_i    = '0;
        drv          = 1'b0;
        spur_hit     = 1'b0;
        if (rst_n && q.size() > 0 && q[0].idx != 0 && cyc >= q[0].ready) begin
            sbr_rvalid_i[q[0].idx-1]             = 1'b1;
            sbr_rdata_i[(q[0].idx-1)*DW +: DW]   = q[0].rdata;
            sbr_err_i[q[0].idx-1]                = q[0].err;
            sbr_rid_i[(q[0].idx-1)*IW +: IW]     = q[0].rid;
            drv = 1'b1;
        end
        for (int k = 0; k < NSBR; k++) begin
            if (force_rv[k]) begin
                sbr_rvalid_i[k]           = 1'b1;
                sbr_rdata_i[k*DW +: DW]   = DW'($urandom);
                if (!(q.size() > 0 && q[0].idx == k + 1)) spur_hit = 1'b1;
            end
        end
        #1;
        if (rst_n) begin
            eidx  = ref_decode(mgr_addr_i, sbr_en_i);
            stall = (q.size() >= MAXT) || (q.size() > 0 && eidx != last_idx);
            egnt  = 1'b0;
            ereq  = '0;
            if (!stall) begin
                if (eidx == 0) egnt = mgr_req_i;
                else begin
                    egnt            = sbr_gnt_i[eidx-1];
                    ereq[eidx-1]    = mgr_req_i;
                end
            end
            check("mgr_gnt", mgr_gnt_o, egnt);
            check("sbr_req", sbr_req_o, ereq);
            erv = (q.size() > 0) && ((q[0].idx == 0) ? (cyc >= q[0].ready) : drv);
            check("mgr_rvalid", mgr_rvalid_o, erv);
            if (erv) begin
                check("mgr_rdata", mgr_rdata_o, (q[0].idx == 0) ? 32'hBADCAB1E : q[0].rdata);
                check("mgr_err", mgr_err_o, (q[0].idx == 0) ? 1'b1 : q[0].err);
                check("mgr_rid", mgr_rid_o, q[0].rid);
                void'(q.pop_front());
            end
            if (mgr_req_i && egnt) begin
                if (eidx != 0) check("sbr_addr", sbr_addr_o, mgr_addr_i);
                t.idx   = eidx;
                t.rid   = mgr_aid_i;
                t.rdata = rsp_data;
                t.err   = (eidx == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
                t.ready = (eidx == 0) ? cyc + 1 : cyc + lat;
                q.push_back(t);
                last_idx = eidx;
            end
            if (spur_hit) spur_model = 1'b1;
        end else begin
            q.delete();
            last_idx   = 0;
            spur_model = 1'b0;
        end
        if (mgr_req_i && mgr_gnt_o) begin
            gnt_cnt++;
            gnt_cyc = cyc;
        end
        if (mgr_rvalid_o) begin
            if (rv_cnt == 0) rv_first = cyc;
            rv_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("spurious_o", spurious_o, spur_model);
    endtask

    task automatic drain(input string tag);
        mgr_req_i = 1'b0;
        for (int i = 0; i < 200 && q.size() > 0; i++) cycle();
        check(tag, q.size(), 0);
    endtask

    task automatic one_req(input logic [31:0] addr, input logic [IW-1:0] aid, input int lt);
        mgr_addr_i = addr;
        mgr_aid_i  = aid;
        lat        = lt;
        gnt_cnt    = 0;
        rv_cnt     = 0;
        mgr_req_i  = 1'b1;
        cycle();
        mgr_req_i  = 1'b0;
        for (int i = 0; i < 20 && rv_cnt == 0; i++) cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; sbr_en_i = '1; mgr_req_i = 1'b0; mgr_addr_i = '0; mgr_we_i = 1'b0;
        mgr_be_i = '1; mgr_wdata_i = '0; mgr_aid_i = '0; sbr_gnt_i = '0;
        force_rv = '0; lat = 1; rsp_data = '0; cyc = 0; checks = 0; errors = 0;
        last_idx = 0; spur_model = 1'b0; gnt_cnt = 0; gnt_cyc = 0; rv_cnt = 0; rv_first = 0;
        @(posedge clk);
        #1;
        repeat (3) cycle();
        rst_n = 1'b1;
        #1;
        check("rst_gnt", mgr_gnt_o, 0);
        check("rst_sbr_req", sbr_req_o, 0);
        check("rst_rvalid", mgr_rvalid_o, 0);
        check("rst_rdata", mgr_rdata_o, 0);
        check("rst_err", mgr_err_o, 0);
        check("rst_rid", mgr_rid_o, 0);
        cycle();

        // Read to sbr1, response two cycles after grant.
        sbr_gnt_i = '1;
        rsp_data  = 32'h0000_1234;
        one_req(32'h2000_0000, 1'b0, 2);
        check("t1_gnt_count", gnt_cnt, 1);
        check("t1_latency", rv_first - gnt_cyc, 2);

        // Unmapped address answers from the error subordinate one cycle later.
        one_req(32'h3000_0000, 1'b1, 1);
        check("t2_latency", rv_first - gnt_cyc, 1);

        // Disabled window falls through to the error subordinate.
        sbr_en_i = 4'b1110;
        one_req(32'h2000_0004, 1'b1, 1);
        check("t3_latency", rv_first - gnt_cyc, 1);
        sbr_en_i = '1;

        // Four outstanding to sbr2, the fifth waits for the first response.
        mgr_addr_i = 32'h2000_1000;
        lat        = 12;
        gnt_cnt    = 0;
        rv_cnt     = 0;
        mgr_req_i  = 1'b1;
        repeat (6) cycle();
        check("t4_grants_at_limit", gnt_cnt, 4);
        for (int i = 0; i < 40 && gnt_cnt < 5; i++) cycle();
        check("t4_fifth_after_pop", gnt_cyc - rv_first, 1);
        drain("t4_drain");

        // Outstanding to sbr1 blocks a request to sbr2 until it completes.
        lat        = 3;
        mgr_addr_i = 32'h2000_0040;
        mgr_req_i  = 1'b1;
        cycle();
        gnt_cnt    = 0;
        rv_cnt     = 0;
        mgr_addr_i = 32'h2000_1040;
        for (int i = 0; i < 20 && gnt_cnt == 0; i++) cycle();
        check("t5_switch_after_pop", gnt_cyc - rv_first, 1);
        drain("t5_drain");

        // Randomized traffic across all windows, edges and unmapped space.
        for (int n = 0; n < 3000; n++) begin
            mgr_req_i   = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 6))
                0, 1, 2, 3: mgr_addr_i = 32'h2000_0000 + 32'($urandom_range(0, 3)) * 32'h1000
                                         + (32'($urandom) & 32'h0000_0FFC);
                4:          mgr_addr_i = 32'h2000_0FFF + 32'($urandom_range(0, 4)) * 32'h1000;
                5:          mgr_addr_i = ($urandom_range(0, 1) == 0) ? 32'h1FFF_FFFF : 32'h2000_4000;
                default:    mgr_addr_i = 32'($urandom);
            endcase
            mgr_we_i    = 1'($urandom_range(0, 1));
            mgr_be_i    = 4'($urandom);
            mgr_wdata_i = 32'($urandom);
            mgr_aid_i   = 1'($urandom_range(0, 1));
            sbr_gnt_i   = 4'($urandom);
            sbr_en_i    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            lat         = $urandom_range(1, 4);
            rsp_data    = 32'($urandom);
            cycle();
        end
        sbr_en_i  = '1;
        sbr_gnt_i = '1;
        drain("rand_drain");

        // Reset with three outstanding, then a stale response arrives.
        lat        = 30;
        mgr_addr_i = 32'h2000_0100;
        gnt_cnt    = 0;
        mgr_req_i  = 1'b1;
        repeat (3) cycle();
        check("t6_outstanding", gnt_cnt, 3);
        mgr_req_i  = 1'b0;
        rst_n      = 1'b0;
        cycle();
        rst_n      = 1'b1;
        force_rv   = 4'b0001;
        cycle();
        force_rv   = '0;
        repeat (2) cycle();
        check("t6_spurious_sticky", spurious_o, 1);
        lat        = 1;
        gnt_cnt    = 0;
        mgr_addr_i = 32'h2000_1100;
        mgr_req_i  = 1'b1;
        cycle();
        check("t6_grant_after_reset", gnt_cnt, 1);
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
